// File: rtl/atm_card_auth.sv
// Card and PIN authentication front end: account table, serial PIN capture and check,
// lockout after repeated failures, and balance write-back when the session ends.
module atm_card_auth #(
    parameter int unsigned balance_width = 20,
    parameter int unsigned num_accounts  = 4,
    parameter int unsigned id_width      = 2,
    parameter int unsigned pin_digits    = 4,
    parameter int unsigned max_tries     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     card_in,
    input  logic [id_width-1:0]      card_id,
    input  logic                     digit_valid,
    input  logic [3:0]               digit,
    input  logic                     pin_enter,
    input  logic                     timeout,
    input  logic                     card_out,
    input  logic [balance_width-1:0] new_balance,
    output logic                     psw_en,
    output logic [balance_width-1:0] current_balance,
    output logic                     wrong_psw,
    output logic                     pin_ok,
    output logic                     card_reject,
    output logic                     busy
);
    localparam int unsigned try_width = $clog2(max_tries + 1);
    localparam int unsigned cnt_width = $clog2(pin_digits + 1);
    localparam int unsigned pin_width = 4 * pin_digits;
    localparam logic [try_width-1:0] try_max = try_width'(max_tries);
    localparam logic [cnt_width-1:0] cnt_max = cnt_width'(pin_digits);

    typedef enum logic [2:0] {StIdle, StCollect, StCheck, StSession, StWriteback} state_e;

    state_e                   state_q, state_d;
    logic [id_width-1:0]      id_q, id_d;
    logic [pin_width-1:0]     pin_buf_q, pin_buf_d;
    logic [cnt_width-1:0]     cnt_q, cnt_d;
    logic [balance_width-1:0] balance_q [num_accounts];
    logic [balance_width-1:0] balance_d [num_accounts];
    logic [try_width-1:0]     tries_q [num_accounts];
    logic [try_width-1:0]     tries_d [num_accounts];
    logic [num_accounts-1:0]  lock_q, lock_d;
    logic [balance_width-1:0] cur_bal_d;
    logic                     psw_en_d, wrong_psw_d, pin_ok_d, card_reject_d, busy_d;
    logic                     id_ok;

    // Stored PIN of entry k is every digit equal to (k+1) mod 10.
    function automatic logic [pin_width-1:0] stored_pin(input logic [id_width-1:0] id);
        logic [3:0] d;
        d = 4'((32'(id) + 32'd1) % 32'd10);
        return {pin_digits{d}};
    endfunction

    assign id_ok = (32'(card_id) < num_accounts);

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        pin_buf_d     = pin_buf_q;
        cnt_d         = cnt_q;
        balance_d     = balance_q;
        tries_d       = tries_q;
        lock_d        = lock_q;
        cur_bal_d     = current_balance;
        psw_en_d      = 1'b0;
        wrong_psw_d   = 1'b0;
        pin_ok_d      = 1'b0;
        card_reject_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The IDLE cycle straight after a session still reports busy and ignores cards.
                if (card_in && !busy) begin
                    if (!id_ok || lock_q[card_id]) begin
                        card_reject_d = 1'b1;
                    end else begin
                        id_d      = card_id;
                        cur_bal_d = balance_q[card_id];
                        psw_en_d  = 1'b1;
                        pin_buf_d = '0;
                        cnt_d     = '0;
                        state_d   = StCollect;
                    end
                end
            end
            StCollect: begin
                if (timeout) begin
                    state_d = StIdle;
                end else begin
                    if (digit_valid && digit <= 4'd9 && cnt_q < cnt_max) begin
                        pin_buf_d = {pin_buf_q[pin_width-5:0], digit};
                        cnt_d     = cnt_q + 1'b1;
                    end
                    if (pin_enter) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (timeout) begin
                    state_d = StIdle;
                end else if (cnt_q == cnt_max && pin_buf_q == stored_pin(id_q)) begin
                    pin_ok_d      = 1'b1;
                    tries_d[id_q] = '0;
                    state_d       = StSession;
                end else begin
                    wrong_psw_d = 1'b1;
                    if (tries_q[id_q] + 1'b1 == try_max) begin
                        lock_d[id_q]  = 1'b1;
                        tries_d[id_q] = '0;
                        state_d       = StIdle;
                    end else begin
                        tries_d[id_q] = tries_q[id_q] + 1'b1;
                        pin_buf_d     = '0;
                        cnt_d         = '0;
                        state_d       = StCollect;
                    end
                end
            end
            StSession: begin
                if (card_out || timeout) begin
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                balance_d[id_q] = new_balance;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle) || (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            id_q            <= '0;
            pin_buf_q       <= '0;
            cnt_q           <= '0;
            lock_q          <= '0;
            current_balance <= '0;
            psw_en          <= 1'b0;
            wrong_psw       <= 1'b0;
            pin_ok          <= 1'b0;
            card_reject     <= 1'b0;
            busy            <= 1'b0;
            for (int k = 0; k < int'(num_accounts); k++) begin
                balance_q[k] <= balance_width'(1000);
                tries_q[k]   <= '0;
            end
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            pin_buf_q       <= pin_buf_d;
            cnt_q           <= cnt_d;
            lock_q          <= lock_d;
            balance_q       <= balance_d;
            tries_q         <= tries_d;
            current_balance <= cur_bal_d;
            psw_en          <= psw_en_d;
            wrong_psw       <= wrong_psw_d;
            pin_ok          <= pin_ok_d;
            card_reject     <= card_reject_d;
            busy            <= busy_d;
        end
    end

endmodule

// File: tb/tb_atm_card_auth.sv
// Bench for atm_card_auth: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural account/session model.
module tb_atm_card_auth;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        card_in = 1'b0;
    logic [1:0]  card_id = '0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = '0;
    logic        pin_enter = 1'b0;
    logic        timeout = 1'b0;
    logic        card_out = 1'b0;
    logic [19:0] new_balance = '0;
    logic        psw_en, wrong_psw, pin_ok, card_reject, busy;
    logic [19:0] current_balance;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    atm_card_auth dut (
        .clk             (clk),
        .rst             (rst),
        .card_in         (card_in),
        .card_id         (card_id),
        .digit_valid     (digit_valid),
        .digit           (digit),
        .pin_enter       (pin_enter),
        .timeout         (timeout),
        .card_out        (card_out),
        .new_balance     (new_balance),
        .psw_en          (psw_en),
        .current_balance (current_balance),
        .wrong_psw       (wrong_psw),
        .pin_ok          (pin_ok),
        .card_reject     (card_reject),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Behavioural model: accounts as integer arrays, the typed PIN as a queue of decimal digits.
    localparam int PhIdle = 0, PhCollect = 1, PhCheck = 2, PhSession = 3, PhWrite = 4;
    int   m_bal [4];
    bit   m_lock [4];
    int   m_tries [4];
    int   m_phase;
    int   m_id;
    int   m_dig [$];
    logic e_psw, e_wrong, e_ok, e_rej, e_busy;
    int   e_cur;

    function automatic int pin_of(int k);
        return ((k + 1) % 10) * 1111;
    endfunction

    function automatic int typed_value();
        int v = 0;
        foreach (m_dig[i]) v = v * 10 + m_dig[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                m_bal[k] = 1000; m_lock[k] = 1'b0; m_tries[k] = 0;
            end
            m_phase = PhIdle; m_id = 0; m_dig.delete();
            e_psw = 0; e_wrong = 0; e_ok = 0; e_rej = 0; e_busy = 0; e_cur = 0;
        end else begin
            automatic bit was_busy = e_busy;
            automatic bit was_idle = (m_phase == PhIdle);
            e_psw = 0; e_wrong = 0; e_ok = 0; e_rej = 0;
            case (m_phase)
                PhIdle: if (card_in && !was_busy) begin
                    if (m_lock[card_id]) e_rej = 1;
                    else begin
                        m_id = int'(card_id); e_cur = m_bal[m_id]; e_psw = 1;
                        m_dig.delete(); m_phase = PhCollect;
                    end
                end
                PhCollect: if (timeout) m_phase = PhIdle;
                else begin
                    if (digit_valid && digit <= 9 && m_dig.size() < 4) m_dig.push_back(int'(digit));
                    if (pin_enter) m_phase = PhCheck;
                end
                PhCheck: if (timeout) m_phase = PhIdle;
                else if (m_dig.size() == 4 && typed_value() == pin_of(m_id)) begin
                    e_ok = 1; m_tries[m_id] = 0; m_phase = PhSession;
                end else begin
                    e_wrong = 1; m_tries[m_id]++; m_dig.delete();
                    if (m_tries[m_id] >= 3) begin
                        m_lock[m_id] = 1; m_tries[m_id] = 0; m_phase = PhIdle;
                    end else m_phase = PhCollect;
                end
                PhSession: if (card_out || timeout) m_phase = PhWrite;
                default: begin m_bal[m_id] = int'(new_balance); m_phase = PhIdle; end
            endcase
            e_busy = !(was_idle && m_phase == PhIdle);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_psw_en", psw_en, e_psw);
            chk("cyc_wrong_psw", wrong_psw, e_wrong);
            chk("cyc_pin_ok", pin_ok, e_ok);
            chk("cyc_card_reject", card_reject, e_rej);
            chk("cyc_busy", busy, e_busy);
            chk("cyc_current_balance", current_balance, e_cur);
        end
    end

    task automatic idle_wait();
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        if (busy !== 1'b0) chk("idle_wait_busy", busy, 0);
    endtask

    task automatic insert(input int id);
        card_id = 2'(id); card_in = 1'b1; @(negedge clk); card_in = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        digit = d; digit_valid = 1'b1; @(negedge clk); digit_valid = 1'b0;
    endtask

    task automatic key4(input logic [3:0] d);
        for (int i = 0; i < 4; i++) key(d);
    endtask

    task automatic enter();
        pin_enter = 1'b1; @(negedge clk); pin_enter = 1'b0; @(negedge clk);
    endtask

    task automatic pulse_timeout();
        timeout = 1'b1; @(negedge clk); timeout = 1'b0; idle_wait();
    endtask

    task automatic eject(input logic [19:0] nb);
        new_balance = nb; card_out = 1'b1; @(negedge clk); card_out = 1'b0; idle_wait();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; chk_en = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_balance", current_balance, 0);
        chk("reset_psw_en", psw_en, 0);

        // Happy path, then write-back visible on re-insert.
        insert(1);
        chk("happy_psw_en", psw_en, 1);
        chk("happy_balance", current_balance, 1000);
        key4(4'd2); enter();
        chk("happy_pin_ok", pin_ok, 1);
        new_balance = 20'd700; card_out = 1'b1; @(negedge clk); card_out = 1'b0;
        @(negedge clk); chk("wb_busy_hold", busy, 1);
        @(negedge clk); chk("wb_busy_low", busy, 0);
        insert(1);
        chk("wb_balance_700", current_balance, 700);
        pulse_timeout();

        // Lockout after three failures.
        insert(2);
        for (int t = 0; t < 3; t++) begin
            key(4'd1); key(4'd2); key(4'd3); key(4'd4); enter();
            chk("lock_wrong_psw", wrong_psw, 1);
        end
        idle_wait();
        insert(2);
        chk("lock_reject", card_reject, 1);
        chk("lock_no_psw_en", psw_en, 0);
        idle_wait();
        insert(0);
        chk("lock_id0_ok", psw_en, 1);

        // Short PIN, then invalid digit with same-cycle digit + enter.
        key(4'd1); key(4'd1); key(4'd1); enter();
        chk("short_wrong", wrong_psw, 1);
        key(4'd1); key(4'hA); key(4'd1); key(4'd1);
        digit = 4'd1; digit_valid = 1'b1; pin_enter = 1'b1; @(negedge clk);
        digit_valid = 1'b0; pin_enter = 1'b0; @(negedge clk);
        chk("invalid_digit_pin_ok", pin_ok, 1);
        eject(20'd1000);

        // Timeout keeps the try counter.
        insert(3); key4(4'd0); enter();
        chk("to_wrong1", wrong_psw, 1);
        pulse_timeout();
        insert(3);
        chk("to_balance", current_balance, 1000);
        key4(4'd0); enter(); key4(4'd0); enter();
        chk("to_wrong3", wrong_psw, 1);
        idle_wait();
        insert(3);
        chk("to_locked", card_reject, 1);
        idle_wait();

        // Ignored card_out in COLLECT and card_in in SESSION.
        insert(0);
        card_out = 1'b1; @(negedge clk); card_out = 1'b0;
        chk("ign_busy", busy, 1);
        key4(4'd1); enter();
        chk("ign_pin_ok", pin_ok, 1);
        card_id = 2'd1; card_in = 1'b1; @(negedge clk); card_in = 1'b0;
        chk("ign_psw_en", psw_en, 0);
        chk("ign_reject", card_reject, 0);
        eject(20'd5);
        insert(0);
        chk("bal_5", current_balance, 5);
        key4(4'd1); enter();

        // Reset in SESSION restores the table.
        #3 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pin_ok", pin_ok, 0);
        chk("rst_balance", current_balance, 0);
        @(negedge clk); rst = 1'b1;
        insert(0);
        chk("rst_reinsert_1000", current_balance, 1000);
        pulse_timeout();

        // Random traffic, digits biased towards the active account's PIN.
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) begin
                #3 rst = 1'b0;
                @(negedge clk); rst = 1'b1;
            end
            card_in     = ($urandom_range(0, 7) == 0);
            card_id     = 2'($urandom_range(0, 3));
            digit_valid = 1'($urandom_range(0, 1));
            digit       = ($urandom_range(0, 3) != 0) ? 4'((m_id + 1) % 10)
                                                      : 4'($urandom_range(0, 15));
            pin_enter   = ($urandom_range(0, 9) == 0);
            timeout     = ($urandom_range(0, 49) == 0);
            card_out    = ($urandom_range(0, 9) == 0);
            new_balance = 20'($urandom);
            @(negedge clk);
        end
        card_in = 0; digit_valid = 0; pin_enter = 0; timeout = 0; card_out = 0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
